// File: rtl/matmul_gen.sv
// matmul_gen: sequential matrix multiplier Z = X * Y (X is MxK, Y is KxN, Z is MxN,
// all row-major, signed two's complement). One multiply-accumulate per cycle against
// external synchronous-read X/Y memories; each Z element costs K+2 cycles.
// Optional feature: define MATMUL_GEN_SAT_EN to clamp Z words to the DATA_WIDTH
// signed range; otherwise Z words are the low DATA_WIDTH accumulator bits.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   start               begin a multiply (sampled only when idle)
//   busy, done          not-idle flag, one-cycle completion pulse
//   x_addr/x_dout       X read port (data returns one cycle after address)
//   y_addr/y_dout       Y read port (data returns one cycle after address)
//   z_addr/z_din/z_wr_en Z write port
module matmul_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 72,
  parameter int unsigned M          = 8,
  parameter int unsigned K          = 8,
  parameter int unsigned N          = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        x_addr,
  output logic [ADDR_WIDTH-1:0]        y_addr,
  input  logic signed [DATA_WIDTH-1:0] x_dout,
  input  logic signed [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0]        z_addr,
  output logic signed [DATA_WIDTH-1:0] z_din,
  output logic                         z_wr_en
);

  localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, FETCH, ACC, WRITE, DONE} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  i_q, i_d;
  logic [JW-1:0]                  j_q, j_d;
  logic [KW-1:0]                  k_q, k_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]           prod;
  logic signed [DATA_WIDTH-1:0]   acc_red;

  logic                           busy_d, done_d, z_wr_en_d;
  logic [ADDR_WIDTH-1:0]          x_addr_d, y_addr_d, z_addr_d;
  logic signed [DATA_WIDTH-1:0]   z_din_d;

  // Full-width signed product of the words addressed in the previous cycle
  assign prod = PW'(x_dout) * PW'(y_dout);

  // Reduce the next accumulator value to a Z word
`ifdef MATMUL_GEN_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    acc_red = acc_d[DATA_WIDTH-1:0];
    if (acc_d > SAT_MAX)      acc_red = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_d < SAT_MIN) acc_red = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  always_comb begin
    acc_red = acc_d[DATA_WIDTH-1:0];
  end
`endif

  // Next-state, loop counters, accumulator, and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        i_d   = '0;
        j_d   = '0;
        k_d   = '0;
        acc_d = '0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        // k=0 has no returned data yet, so it restarts the sum instead
        acc_d = (k_q == '0) ? '0 : acc_q + ACC_WIDTH'(prod);
        if (k_q == KW'(K - 1)) begin
          k_d     = '0;
          state_d = ACC;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ACC: begin
        acc_d   = acc_q + ACC_WIDTH'(prod);
        state_d = WRITE;
      end
      WRITE: begin
        state_d = FETCH;
        if (j_q != JW'(N - 1)) begin
          j_d = j_q + JW'(1);
        end else begin
          j_d = '0;
          if (i_q != IW'(M - 1)) i_d = i_q + IW'(1);
          else                   state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    z_wr_en_d = (state_d == WRITE);
    x_addr_d  = '0;
    y_addr_d  = '0;
    z_addr_d  = '0;
    z_din_d   = '0;
    if (state_d == FETCH) begin
      x_addr_d = ADDR_WIDTH'(32'(i_d) * K + 32'(k_d));
      y_addr_d = ADDR_WIDTH'(32'(k_d) * N + 32'(j_d));
    end
    if (state_d == WRITE) begin
      z_addr_d = ADDR_WIDTH'(32'(i_d) * N + 32'(j_d));
      z_din_d  = acc_red;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      z_wr_en <= 1'b0;
      x_addr  <= '0;
      y_addr  <= '0;
      z_addr  <= '0;
      z_din   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy    <= busy_d;
      done    <= done_d;
      z_wr_en <= z_wr_en_d;
      x_addr  <= x_addr_d;
      y_addr  <= y_addr_d;
      z_addr  <= z_addr_d;
      z_din   <= z_din_d;
    end
  end

endmodule

// File: tb/tb_matmul_gen.sv
// tb_matmul_gen: directed, table-driven bench for matmul_gen. Four instances cover
// 2x2x2, 2x3x4, an 8-bit 1x2x1 range case and a K=1 3x1x3 back-to-back case.
module tb_matmul_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic   reset;
  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- instance A: M=K=N=2, 32-bit ----------------
  logic start_a = 1'b0, busy_a, done_a, zwe_a;
  logic [5:0] xa_a, ya_a, za_a;
  logic signed [31:0] xd_a, yd_a, zd_a;
  logic signed [31:0] xm_a [4];
  logic signed [31:0] ym_a [4];
  always @(posedge clock) begin
    xd_a <= xm_a[xa_a[1:0]];
    yd_a <= ym_a[ya_a[1:0]];
  end
  matmul_gen #(.DATA_WIDTH(32), .ACC_WIDTH(72), .M(2), .K(2), .N(2), .ADDR_WIDTH(6)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .x_addr(xa_a), .y_addr(ya_a), .x_dout(xd_a), .y_dout(yd_a),
    .z_addr(za_a), .z_din(zd_a), .z_wr_en(zwe_a));

  // ---------------- instance B: M=2, K=3, N=4 ----------------
  logic start_b = 1'b0, busy_b, done_b, zwe_b;
  logic [5:0] xa_b, ya_b, za_b;
  logic signed [31:0] xd_b, yd_b, zd_b;
  logic signed [31:0] xm_b [16];
  logic signed [31:0] ym_b [16];
  always @(posedge clock) begin
    xd_b <= xm_b[xa_b[3:0]];
    yd_b <= ym_b[ya_b[3:0]];
  end
  matmul_gen #(.DATA_WIDTH(32), .ACC_WIDTH(72), .M(2), .K(3), .N(4), .ADDR_WIDTH(6)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .x_addr(xa_b), .y_addr(ya_b), .x_dout(xd_b), .y_dout(yd_b),
    .z_addr(za_b), .z_din(zd_b), .z_wr_en(zwe_b));

  // ---------------- instance C: 8-bit, M=N=1, K=2 ----------------
  logic start_c = 1'b0, busy_c, done_c, zwe_c;
  logic [1:0] xa_c, ya_c, za_c;
  logic signed [7:0] xd_c, yd_c, zd_c;
  logic signed [7:0] xm_c [2];
  logic signed [7:0] ym_c [2];
  always @(posedge clock) begin
    xd_c <= xm_c[xa_c[0]];
    yd_c <= ym_c[ya_c[0]];
  end
  matmul_gen #(.DATA_WIDTH(8), .ACC_WIDTH(16), .M(1), .K(2), .N(1), .ADDR_WIDTH(2)) u_c (
    .clock(clock), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
    .x_addr(xa_c), .y_addr(ya_c), .x_dout(xd_c), .y_dout(yd_c),
    .z_addr(za_c), .z_din(zd_c), .z_wr_en(zwe_c));

  // ---------------- instance D: K=1, M=N=3 ----------------
  logic start_d = 1'b0, busy_d, done_d, zwe_d;
  logic [5:0] xa_d, ya_d, za_d;
  logic signed [31:0] xd_d, yd_d, zd_d;
  logic signed [31:0] xm_d [4];
  logic signed [31:0] ym_d [4];
  always @(posedge clock) begin
    xd_d <= xm_d[xa_d[1:0]];
    yd_d <= ym_d[ya_d[1:0]];
  end
  matmul_gen #(.DATA_WIDTH(32), .ACC_WIDTH(72), .M(3), .K(1), .N(3), .ADDR_WIDTH(6)) u_d (
    .clock(clock), .reset(reset), .start(start_d), .busy(busy_d), .done(done_d),
    .x_addr(xa_d), .y_addr(ya_d), .x_dout(xd_d), .y_dout(yd_d),
    .z_addr(za_d), .z_din(zd_d), .z_wr_en(zwe_d));

  // ---------------- observed Z writes and done pulses ----------------
  typedef struct { longint cyc; int addr; longint data; } wr_t;
  wr_t    wq [$];
  longint dq [$];

  function automatic wr_t mk(input longint c, input int a, input longint d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    return w;
  endfunction

  always @(negedge clock) begin
    if (zwe_a) wq.push_back(mk(cyc, int'(za_a), longint'(zd_a)));
    if (zwe_b) wq.push_back(mk(cyc, int'(za_b), longint'(zd_b)));
    if (zwe_c) wq.push_back(mk(cyc, int'(za_c), longint'(zd_c)));
    if (zwe_d) wq.push_back(mk(cyc, int'(za_d), longint'(zd_d)));
    if (done_a || done_b || done_c || done_d) dq.push_back(cyc);
  end

  // ---------------- expected writes and done cycles (cycle 1 = after start edge) -------
  typedef struct { int cyc; int addr; longint data; } exp_t;
  exp_t ex  [$];
  int   exd [$];

  task automatic add_ex(input int c, input int a, input longint d);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    ex.push_back(e);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    ex.delete(); exd.delete(); wq.delete(); dq.delete();
  endtask

  task automatic check_run(input string nm, input longint t0);
    chk({nm, "_nwrites"}, longint'(wq.size()), longint'(ex.size()));
    for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
      chk($sformatf("%s_w%0d_cycle", nm, i), wq[i].cyc - t0 + 1, longint'(ex[i].cyc));
      chk($sformatf("%s_w%0d_addr", nm, i), longint'(wq[i].addr), longint'(ex[i].addr));
      chk($sformatf("%s_w%0d_data", nm, i), wq[i].data, ex[i].data);
    end
    chk({nm, "_ndone"}, longint'(dq.size()), longint'(exd.size()));
    for (int i = 0; i < exd.size() && i < dq.size(); i++)
      chk($sformatf("%s_done%0d_cycle", nm, i), dq[i] - t0 + 1, longint'(exd[i]));
  endtask

  // ---------------- 2x2x2 vector table ----------------
  typedef struct { string name; logic [3:0][31:0] x; logic [3:0][31:0] y; logic [3:0][31:0] z; } vec_t;
  vec_t vt [3];

  task automatic set_vec(input int v, input string nm,
                         input int x0, input int x1, input int x2, input int x3,
                         input int y0, input int y1, input int y2, input int y3,
                         input int z0, input int z1, input int z2, input int z3);
    vt[v].name = nm;
    vt[v].x[0] = 32'(x0); vt[v].x[1] = 32'(x1); vt[v].x[2] = 32'(x2); vt[v].x[3] = 32'(x3);
    vt[v].y[0] = 32'(y0); vt[v].y[1] = 32'(y1); vt[v].y[2] = 32'(y2); vt[v].y[3] = 32'(y3);
    vt[v].z[0] = 32'(z0); vt[v].z[1] = 32'(z1); vt[v].z[2] = 32'(z2); vt[v].z[3] = 32'(z3);
  endtask

  task automatic load_a(input int v);
    for (int e = 0; e < 4; e++) begin
      xm_a[e] = $signed(vt[v].x[e]);
      ym_a[e] = $signed(vt[v].y[e]);
    end
  endtask

  task automatic run_a(input int v);
    longint t0;
    load_a(v);
    clear_log();
    start_a = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start_a = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    for (int e = 0; e < 4; e++) add_ex(4 * e + 4, e, longint'($signed(vt[v].z[e])));
    exd.push_back(17);
    check_run(vt[v].name, t0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    longint t0;
    int xv [3];
    int yv [3];
    logic signed [7:0] c_x [2];
    logic signed [7:0] c_y [2];
    int c_exp [2];

    set_vec(0, "ident", 1, 2, 3, 4,   1, 0, 0, 1,   1, 2, 3, 4);
    set_vec(1, "basic", 1, 2, 3, 4,   5, 6, 7, 8,   19, 22, 43, 50);
    set_vec(2, "neg",  -1, 2, -3, 4,  5, 6, 7, 8,   9, 10, 13, 14);

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", longint'(busy_a), 0);
    chk("rst_done", longint'(done_a), 0);
    chk("rst_zwe", longint'(zwe_a), 0);
    chk("rst_xaddr", longint'(xa_a), 0);
    chk("rst_zaddr", longint'(za_a), 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Cycle-by-cycle address/strobe sequence of the first element
    load_a(0);
    clear_log();
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    chk("c1_busy", longint'(busy_a), 1);
    chk("c1_xaddr", longint'(xa_a), 0);
    chk("c1_yaddr", longint'(ya_a), 0);
    @(posedge clock); #1;
    chk("c2_xaddr", longint'(xa_a), 1);
    chk("c2_yaddr", longint'(ya_a), 2);
    @(posedge clock); #1;
    chk("c3_acc_xaddr", longint'(xa_a), 0);
    chk("c3_acc_yaddr", longint'(ya_a), 0);
    chk("c3_acc_zwe", longint'(zwe_a), 0);
    chk("c3_acc_zdin", longint'(zd_a), 0);
    @(posedge clock); #1;
    chk("c4_zwe", longint'(zwe_a), 1);
    chk("c4_zaddr", longint'(za_a), 0);
    chk("c4_zdin", longint'(zd_a), 1);
    repeat (13) @(posedge clock);
    #1;
    chk("c17_done", longint'(done_a), 1);
    chk("c17_busy", longint'(busy_a), 1);
    @(posedge clock); #1;
    chk("c18_done", longint'(done_a), 0);
    chk("c18_busy", longint'(busy_a), 0);

    // Table-driven 2x2x2 runs
    for (int v = 0; v < 3; v++) run_a(v);

    // Reset during FETCH of element 2 aborts the run
    load_a(1);
    clear_log();
    start_a = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start_a = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("abort_c9_xaddr", longint'(xa_a), 2);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("abort_busy", longint'(busy_a), 0);
    chk("abort_zwe", longint'(zwe_a), 0);
    chk("abort_xaddr", longint'(xa_a), 0);
    repeat (20) @(posedge clock);
    #1;
    add_ex(4, 0, 19);
    add_ex(8, 1, 22);
    check_run("abort", t0);
    run_a(1);

    // M=2, K=3, N=4: X all 1, Y all 2
    for (int e = 0; e < 16; e++) begin
      xm_b[e] = 1;
      ym_b[e] = 2;
    end
    clear_log();
    start_b = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start_b = 1'b0;
    repeat (45) @(posedge clock);
    #1;
    for (int e = 0; e < 8; e++) add_ex(5 * e + 5, e, 6);
    exd.push_back(41);
    check_run("m2k3n4", t0);

    // 8-bit range: saturate or wrap depending on build
    c_x[0] = 8'sd127;  c_y[0] = 8'sd127;
    c_x[1] = -8'sd128; c_y[1] = 8'sd127;
`ifdef MATMUL_GEN_SAT_EN
    c_exp[0] = 127;  c_exp[1] = -128;
`else
    c_exp[0] = 2;    c_exp[1] = 0;
`endif
    for (int v = 0; v < 2; v++) begin
      xm_c[0] = c_x[v]; xm_c[1] = c_x[v];
      ym_c[0] = c_y[v]; ym_c[1] = c_y[v];
      clear_log();
      start_c = 1'b1;
      @(posedge clock); #1;
      t0 = cyc;
      start_c = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      add_ex(4, 0, longint'(c_exp[v]));
      exd.push_back(5);
      check_run($sformatf("dw8_v%0d", v), t0);
    end

    // K=1, M=N=3, start held high: back-to-back runs with one idle cycle
    xv[0] = 1; xv[1] = -2; xv[2] = 3;
    yv[0] = 4; yv[1] = 5;  yv[2] = -6;
    for (int e = 0; e < 3; e++) begin
      xm_d[e] = xv[e];
      ym_d[e] = yv[e];
    end
    clear_log();
    start_d = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    for (int c = 1; c <= 80; c++) begin
      if (c == 29 || c == 58) chk($sformatf("k1_c%0d_idle_busy", c), longint'(busy_d), 0);
      if (c == 30) chk("k1_c30_busy", longint'(busy_d), 1);
      @(posedge clock); #1;
    end
    start_d = 1'b0;
    repeat (25) @(posedge clock);
    #1;
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 9; e++)
        add_ex(29 * r + 3 * e + 3, e, longint'(xv[e / 3] * yv[e % 3]));
      exd.push_back(29 * r + 28);
    end
    check_run("k1_b2b", t0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
